// File: rtl/key_event_filter.sv
// key_event_filter
//   Debounces one raw push-button and turns it into clean single-cycle
//   events: press, release and long-press. One instance per button.
//   Optional macro AUTO_REPEAT_EN: after long_pulse, press_pulse repeats
//   every REPEAT_CYCLES cycles while the key stays held.
// Ports
//   clk           in  system clock
//   rst           in  synchronous active-high reset
//   key_in        in  raw asynchronous button level
//   key_level     out debounced pressed level (1 = pressed)
//   press_pulse   out 1-cycle pulse on accepted press (and repeats)
//   release_pulse out 1-cycle pulse on accepted release
//   long_pulse    out 1-cycle pulse, at most one per press
module key_event_filter #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_CYCLES - 1);
   localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

   state_t         state_q, state_d;
   logic           s1_q, s2_q;
   logic [DBW-1:0] db_q, db_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           long_done_q, long_done_d;
   logic           level_q, level_d;
   logic           press_q, press_d;
   logic           rel_q, rel_d;
   logic           long_q, long_d;
   logic           active;

`ifdef AUTO_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_q, rep_d;
`endif

   assign active = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // synchronizer parks at the released level so a held key re-debounces
         s1_q        <= INACTIVE;
         s2_q        <= INACTIVE;
         state_q     <= IDLE;
         db_q        <= '0;
         hold_q      <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         rel_q       <= 1'b0;
         long_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         s1_q        <= key_in;
         s2_q        <= s1_q;
         state_q     <= state_d;
         db_q        <= db_d;
         hold_q      <= hold_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         long_q      <= long_d;
`ifdef AUTO_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      db_d        = db_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_d       = rep_q;
`endif

      // hold time keeps running through release debounce, so a long press
      // can still be reported while a release is being confirmed
      if (state_q == HELD || state_q == DB_RELEASE) begin
         if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
         end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
         end
      end

`ifdef AUTO_REPEAT_EN
      // long_done_q is only set the cycle after long_pulse, so a repeat
      // can never land on the same cycle as it
      if (state_q == HELD && long_done_q) begin
         if (rep_q == REP_MAX) begin
            rep_d   = '0;
            press_d = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
`endif

      case (state_q)
         IDLE: begin
            if (active) begin
               state_d = DB_PRESS;
               db_d    = '0;
            end
         end
         DB_PRESS: begin
            if (!active) begin
               state_d = IDLE;
            end else if (db_q == DB_MAX) begin
               state_d     = HELD;
               level_d     = 1'b1;
               press_d     = 1'b1;
               hold_d      = '0;
               long_done_d = 1'b0;
`ifdef AUTO_REPEAT_EN
               rep_d       = '0;
`endif
            end else begin
               db_d = db_q + 1'b1;
            end
         end
         HELD: begin
            if (!active) begin
               state_d = DB_RELEASE;
               db_d    = '0;
            end
         end
         DB_RELEASE: begin
            if (active) begin
               state_d = HELD;
            end else if (db_q == DB_MAX) begin
               state_d     = IDLE;
               level_d     = 1'b0;
               rel_d       = 1'b1;
               long_done_d = 1'b0;
`ifdef AUTO_REPEAT_EN
               rep_d       = '0;
`endif
            end else begin
               db_d = db_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign long_pulse    = long_q;

endmodule
